s64x7_bus_narrower: RTL and testbench

- Downstream bus stage for the S64X7 core.
- Consumes the core's 64-bit Wishbone-style master port (adr/cyc/stb/sel/we/vpa/dat) and generates the ack that the core's ack_i expects.
- Converts each 64-bit request into a sequence of 16-bit cycles on a narrow external bus, issuing cycles only for selected halfword lanes.
- Assembles read data, and reports a per-lane timeout as a bus error.

---
 rtl/s64x7_bus_narrower_if.sv | 49 ++++
 rtl/s64x7_bus_narrower.sv | 156 +++++++++++++++
 tb/tb_s64x7_bus_narrower.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/s64x7_bus_narrower_if.sv
// S64X7 bus narrower signal bundle.
//
// Carries both sides of the narrower: the core's 64-bit Wishbone-style
// request/response and the 16-bit narrow external bus. Signal names keep the
// narrower's own view (_i = into the narrower, _o = out of it).
//
// Modports:
//   slave  - the narrower itself: responds to the core, drives the narrow bus
//   master - the environment: the core issuing requests plus the narrow-bus
//            target answering cycles
//
// Core side   : adr_i[60:0] cyc_i stb_i sel_i[7:0] we_i vpa_i dat_i[63:0]
//               ack_o err_o dat_o[63:0]
// Narrow side : m_adr_o[62:0] m_cyc_o m_stb_o m_sel_o[1:0] m_we_o m_vpa_o
//               m_dat_o[15:0] m_dat_i[15:0] m_ack_i
interface s64x7_bus_narrower_if;
  logic [60:0] adr_i;
  logic        cyc_i;
  logic        stb_i;
  logic [7:0]  sel_i;
  logic        we_i;
  logic        vpa_i;
  logic [63:0] dat_i;
  logic        ack_o;
  logic        err_o;
  logic [63:0] dat_o;

  logic [62:0] m_adr_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic [1:0]  m_sel_o;
  logic        m_we_o;
  logic        m_vpa_o;
  logic [15:0] m_dat_o;
  logic [15:0] m_dat_i;
  logic        m_ack_i;

  modport slave (
    input  adr_i, cyc_i, stb_i, sel_i, we_i, vpa_i, dat_i, m_dat_i, m_ack_i,
    output ack_o, err_o, dat_o,
    output m_adr_o, m_cyc_o, m_stb_o, m_sel_o, m_we_o, m_vpa_o, m_dat_o
  );

  modport master (
    output adr_i, cyc_i, stb_i, sel_i, we_i, vpa_i, dat_i, m_dat_i, m_ack_i,
    input  ack_o, err_o, dat_o,
    input  m_adr_o, m_cyc_o, m_stb_o, m_sel_o, m_we_o, m_vpa_o, m_dat_o
  );
endinterface

// File: rtl/s64x7_bus_narrower.sv
// S64X7 bus narrower.
//
// Accepts one 64-bit request from the core, replays it as a run of 16-bit
// cycles on the narrow bus (one per selected halfword lane, ascending), packs
// read halfwords into a 64-bit result and answers the core with a single
// ack_o pulse, or err_o when a lane is not acknowledged within TIMEOUT cycles.
//
// Ports:
//   clk_i    - clock, all state on the rising edge
//   reset_i  - synchronous reset, active low
//   bus      - s64x7_bus_narrower_if.slave (core request/response + narrow bus)
//
// Parameters:
//   TIMEOUT  - cycles allowed per lane before abort (0 disables), 0..255
module s64x7_bus_narrower #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  s64x7_bus_narrower_if.slave  bus
);

  localparam bit        TMO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [60:0] r_adr;
  logic [7:0]  r_sel;
  logic        r_we;
  logic        r_vpa;
  logic [63:0] r_wdat;
  logic [63:0] r_buf, w_buf_nxt;
  logic [63:0] r_dato;
  logic [1:0]  r_lane, w_lane_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_err, w_err_nxt;
  logic [2:0]  w_hit;
  logic        w_accept;
  logic        w_xfer;
  logic        w_tmo;

  // Lane n is live when either byte of halfword n is selected.
  function automatic logic [3:0] lane_mask(input logic [7:0] sel);
    logic [3:0] m;
    for (int n = 0; n < 4; n++) m[n] = |sel[2*n +: 2];
    return m;
  endfunction

  // Lowest live lane at or above 'start'; result is {found, lane}.
  function automatic logic [2:0] first_lane_from(input logic [3:0] mask,
                                                 input logic [2:0] start);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= start)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign w_accept = (r_state == IDLE) && bus.cyc_i && bus.stb_i;
  assign w_xfer   = (r_state == XFER);
  // Abort only when the final allowed cycle passes without an ack.
  assign w_tmo    = TMO_EN && !bus.m_ack_i && (r_cnt == TMO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_buf_nxt   = r_buf;
    w_hit       = 3'b000;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_buf_nxt = '0;
          w_err_nxt = 1'b0;
          w_cnt_nxt = '0;
          w_hit     = first_lane_from(lane_mask(bus.sel_i), 3'd0);
          if (w_hit[2]) begin
            w_state_nxt = XFER;
            w_lane_nxt  = w_hit[1:0];
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      XFER: begin
        if (!bus.cyc_i) begin
          // Core gave up: leave quietly, no completion pulse.
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (bus.m_ack_i) begin
          if (!r_we) w_buf_nxt[{r_lane, 4'b0000} +: 16] = bus.m_dat_i;
          w_cnt_nxt = '0;
          w_hit     = first_lane_from(lane_mask(r_sel), {1'b0, r_lane} + 3'd1);
          if (w_hit[2]) w_lane_nxt = w_hit[1:0];
          else          w_state_nxt = DONE;
        end else if (w_tmo) begin
          w_state_nxt = DONE;
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
      r_adr   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_vpa   <= 1'b0;
      r_wdat  <= '0;
      r_buf   <= '0;
      r_dato  <= '0;
      r_lane  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lane  <= w_lane_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_buf   <= w_buf_nxt;
      if (w_accept) begin
        r_adr  <= bus.adr_i;
        r_sel  <= bus.sel_i;
        r_we   <= bus.we_i;
        r_vpa  <= bus.vpa_i;
        r_wdat <= bus.dat_i;
      end
      // Result register only changes when a request completes, so an
      // abandoned or in-flight request leaves the previous result visible.
      if (w_state_nxt == DONE) r_dato <= w_buf_nxt;
    end
  end

  assign bus.ack_o   = (r_state == DONE) && !r_err;
  assign bus.err_o   = (r_state == DONE) &&  r_err;
  assign bus.dat_o   = r_dato;
  assign bus.m_cyc_o = w_xfer;
  assign bus.m_stb_o = w_xfer;
  assign bus.m_adr_o = w_xfer ? {r_adr, r_lane} : '0;
  assign bus.m_sel_o = w_xfer ? r_sel[{r_lane, 1'b0} +: 2] : 2'b00;
  assign bus.m_we_o  = w_xfer && r_we;
  assign bus.m_dat_o = w_xfer ? r_wdat[{r_lane, 4'b0000} +: 16] : 16'h0000;
  assign bus.m_vpa_o = r_vpa;

endmodule

// File: tb/tb_s64x7_bus_narrower.sv
// Bench for s64x7_bus_narrower: table of directed transactions with their
// expected completion cycle/status/data, hand-written reset sequences, and
// randomized transactions scored against a lane-level reference model.
module tb_s64x7_bus_narrower;

  localparam int TO = 4;

  logic clk;
  logic reset_i;
  s64x7_bus_narrower_if bus();

  s64x7_bus_narrower #(.TIMEOUT(TO)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [60:0]      adr;
    logic [7:0]       sel;
    logic             we;
    logic             vpa;
    logic [63:0]      wdat;
    logic [3:0][7:0]  waits;   // slave wait states per lane, >= TO means never ack
    logic [3:0][15:0] rdat;    // slave read data per lane
    int               drop;    // cycle in which the core drops cyc_i (0 = never)
    int               exp_end; // cycle of ack_o/err_o
    logic             exp_err;
    logic [63:0]      exp_dat;
  } txn_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] last_dat = '0;
  txn_t        vec[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [60:0] adr, input logic [7:0] sel, input logic we,
                              input logic [63:0] wdat, input logic [31:0] waits,
                              input logic [63:0] rdat, input int drop, input int e_end,
                              input logic e_err, input logic [63:0] e_dat);
    txn_t t;
    t.adr = adr; t.sel = sel; t.we = we; t.vpa = ~we; t.wdat = wdat;
    t.waits = waits; t.rdat = rdat; t.drop = drop;
    t.exp_end = e_end; t.exp_err = e_err; t.exp_dat = e_dat;
    return t;
  endfunction

  // Reference: walk the selected lanes in order, each costs (wait+1) cycles
  // if acked in time, else TO cycles and the request ends in error.
  function automatic txn_t model(input txn_t t);
    int          c = 1;
    bit          err = 0;
    logic [63:0] d = '0;
    for (int n = 0; n < 4; n++) begin
      if (t.sel[2*n +: 2] != 0 && !err) begin
        if (int'(t.waits[n]) < TO) begin
          c += int'(t.waits[n]) + 1;
          if (!t.we) d[16*n +: 16] = t.rdat[n];
        end else begin
          c += TO;
          err = 1;
        end
      end
    end
    t.exp_end = c; t.exp_err = err; t.exp_dat = d;
    return t;
  endfunction

  task automatic run(input txn_t t, input string tag);
    int   lane_at[64];
    logic ack_at[64];
    int   c, last, act;
    bit   ab;
    for (int i = 0; i < 64; i++) begin lane_at[i] = -1; ack_at[i] = 1'b0; end
    c = 1; ab = 0;
    for (int n = 0; n < 4; n++) begin
      if (t.sel[2*n +: 2] != 0 && !ab) begin
        for (int k = 0; k < 256; k++) begin
          lane_at[c] = n;
          if (k == int'(t.waits[n])) begin ack_at[c] = 1'b1; c++; break; end
          if (k == TO - 1) begin ab = 1; c++; break; end
          c++;
        end
      end
    end
    @(posedge clk); #1;
    bus.adr_i = t.adr; bus.sel_i = t.sel; bus.we_i = t.we; bus.vpa_i = t.vpa;
    bus.dat_i = t.wdat; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    last = (t.drop > 0) ? t.drop + 3 : t.exp_end;
    for (int cc = 0; cc <= last && cc < 64; cc++) begin
      @(negedge clk);
      act = (t.drop > 0 && cc > t.drop) ? -1 : lane_at[cc];
      check($sformatf("%s c%0d m_cyc", tag, cc), 64'(bus.m_cyc_o), 64'(act >= 0));
      if (act >= 0) begin
        check($sformatf("%s c%0d m_stb", tag, cc), 64'(bus.m_stb_o), 64'(1));
        check($sformatf("%s c%0d m_adr", tag, cc), 64'(bus.m_adr_o), 64'({t.adr, 2'(act)}));
        check($sformatf("%s c%0d m_sel", tag, cc), 64'(bus.m_sel_o), 64'(t.sel[2*act +: 2]));
        check($sformatf("%s c%0d m_we", tag, cc), 64'(bus.m_we_o), 64'(t.we));
        check($sformatf("%s c%0d m_vpa", tag, cc), 64'(bus.m_vpa_o), 64'(t.vpa));
        check($sformatf("%s c%0d m_dat", tag, cc), 64'(bus.m_dat_o), 64'(t.wdat[16*act +: 16]));
        bus.m_ack_i = ack_at[cc];
        bus.m_dat_i = ack_at[cc] ? t.rdat[act] : 16'($urandom);
      end else begin
        bus.m_ack_i = 1'b0;
        bus.m_dat_i = 16'($urandom);
      end
      if (t.drop == 0 && cc == t.exp_end) begin
        check($sformatf("%s c%0d ack_o", tag, cc), 64'(bus.ack_o), 64'(!t.exp_err));
        check($sformatf("%s c%0d err_o", tag, cc), 64'(bus.err_o), 64'(t.exp_err));
        check($sformatf("%s c%0d dat_o", tag, cc), bus.dat_o, t.exp_dat);
        last_dat = t.exp_dat;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
      end else begin
        check($sformatf("%s c%0d ack_o idle", tag, cc), 64'(bus.ack_o), 64'(0));
        check($sformatf("%s c%0d err_o idle", tag, cc), 64'(bus.err_o), 64'(0));
        check($sformatf("%s c%0d dat_o held", tag, cc), bus.dat_o, last_dat);
      end
      if (t.drop > 0 && cc == t.drop) begin bus.cyc_i = 1'b0; bus.stb_i = 1'b0; end
    end
    bus.m_ack_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   r;

    vec[0] = mk(61'h2222222, 8'h02, 1'b1, 64'h4141414141414141, 32'h0, 64'h0,
                0, 2, 1'b0, 64'h0);
    vec[1] = mk(61'h100, 8'hF0, 1'b0, 64'h0, 32'h0, 64'h8100_0081_0000_0000,
                0, 3, 1'b0, 64'h8100_0081_0000_0000);
    vec[2] = mk(61'h1234, 8'hFF, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 32'h02020202,
                64'h4444_3333_2222_1111, 0, 13, 1'b0, 64'h4444_3333_2222_1111);
    vec[3] = mk(61'h55, 8'hFF, 1'b0, 64'h0, 32'h0000FF00, 64'h1111_2222_3333_BEEF,
                0, 6, 1'b1, 64'h0000_0000_0000_BEEF);
    vec[4] = mk(61'h7, 8'h03, 1'b0, 64'h0, 32'h00000003, 64'h0000_0000_0000_CAFE,
                0, 5, 1'b0, 64'h0000_0000_0000_CAFE);
    vec[5] = mk(61'h9, 8'h00, 1'b0, 64'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                0, 1, 1'b0, 64'h0);
    vec[6] = mk(61'hABC, 8'hFF, 1'b0, 64'h0, 32'h00000300, 64'h7777_6666_5555_4444,
                3, 0, 1'b0, 64'h0);
    vec[7] = mk(61'hDEF, 8'h0C, 1'b1, 64'h0123_4567_89AB_CDEF, 32'h00000100, 64'h0,
                0, 3, 1'b0, 64'h0);
    vec[8] = mk(61'h1F0F0, 8'h81, 1'b0, 64'h0, 32'h0, 64'hA5A5_0000_0000_5A5A,
                0, 3, 1'b0, 64'hA5A5_0000_0000_5A5A);

    // Reset held with a live request
    reset_i = 1'b0;
    bus.adr_i = 61'h3; bus.sel_i = 8'hFF; bus.we_i = 1'b0; bus.vpa_i = 1'b1;
    bus.dat_i = 64'h0; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    bus.m_ack_i = 1'b0; bus.m_dat_i = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset m_cyc", 64'(bus.m_cyc_o), 64'(0));
    check("reset ack_o", 64'(bus.ack_o), 64'(0));
    check("reset err_o", 64'(bus.err_o), 64'(0));
    check("reset dat_o", bus.dat_o, 64'h0);
    check("reset m_adr", 64'(bus.m_adr_o), 64'h0);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; reset_i = 1'b1;

    for (int i = 0; i < 9; i++) run(vec[i], $sformatf("vec%0d", i));

    // Reset in the middle of a transfer
    @(posedge clk); #1;
    bus.sel_i = 8'hFF; bus.we_i = 1'b0; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    bus.m_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst m_cyc before", 64'(bus.m_cyc_o), 64'(1));
    reset_i = 1'b0;
    @(negedge clk);
    check("midrst m_cyc", 64'(bus.m_cyc_o), 64'(0));
    check("midrst ack_o", 64'(bus.ack_o), 64'(0));
    check("midrst err_o", 64'(bus.err_o), 64'(0));
    check("midrst dat_o", bus.dat_o, 64'h0);
    reset_i = 1'b1; bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    last_dat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("midrst after%0d ack|err", i), 64'(bus.ack_o | bus.err_o), 64'(0));
    end

    // Randomized transactions against the reference model
    for (int i = 0; i < 60; i++) begin
      t.adr  = 61'({$urandom(), $urandom()});
      t.sel  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      t.we   = 1'($urandom);
      t.vpa  = 1'($urandom);
      t.wdat = {$urandom(), $urandom()};
      t.rdat = {$urandom(), $urandom()};
      t.drop = 0;
      for (int n = 0; n < 4; n++) begin
        r = int'($urandom_range(0, 9));
        t.waits[n] = (r < 5) ? 8'(r % 3) : (r < 8) ? 8'd3 : (r == 8) ? 8'd4 : 8'd255;
      end
      t = model(t);
      run(t, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
